countdown_ctrl: RTL

//  Control stage directly upstream of the 4-bit down counter. Generates the counter's

---
 rtl/countdown_ctrl_if.sv | 28 ++
 rtl/countdown_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/countdown_ctrl_if.sv
// Handshake and counter-drive bundle between the control unit,
// countdown_ctrl and its 4-bit down counter.
interface countdown_ctrl_if;
    logic       start;
    logic [3:0] load_val;
    logic       abort;
    logic       co;
    logic       clk_en;
    logic [3:0] pin;
    logic       ld;
    logic       cen;
    logic       rst_cu;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, load_val, abort, co,
        input  clk_en, pin, ld, cen, rst_cu,
        input  busy, done, err
    );

    modport slave (
        input  start, load_val, abort, co,
        output clk_en, pin, ld, cen, rst_cu,
        output busy, done, err
    );
endinterface

// File: rtl/countdown_ctrl.sv
// Tick generator and load/count/clear sequencer for one 4-bit down counter,
// with start/busy/done handshake and a sticky missing-co error flag.
module countdown_ctrl #(
    parameter int DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    countdown_ctrl_if.slave  bus
);
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, COUNT, DONE, ABORT
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          clk_en_q, clk_en_d;
    logic          co_q, co_d;
    logic [3:0]    pin_q, pin_d;
    logic [4:0]    rem_q, rem_d;
    logic          ld_q, ld_d;
    logic          cen_q, cen_d;
    logic          rst_cu_q, rst_cu_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    always_comb begin
        presc_d  = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
        clk_en_d = (presc_q == PMAX);
        co_d     = bus.co;
        state_d  = state_q;
        pin_d    = pin_q;
        rem_d    = rem_q;
        ld_d     = ld_q;
        cen_d    = cen_q;
        rst_cu_d = rst_cu_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                // abort outranks a simultaneous start
                if (bus.start && !bus.abort) begin
                    pin_d   = bus.load_val;
                    ld_d    = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (clk_en_q) begin
                    ld_d = 1'b0;
                    if (pin_q == 4'd0) begin
                        state_d = DONE;
                    end else begin
                        cen_d   = 1'b1;
                        rem_d   = {1'b0, pin_q};
                        state_d = COUNT;
                    end
                end
            end
            COUNT: begin
                if (clk_en_q) begin
                    rem_d = rem_q - 5'd1;
                    if (co_q) begin
                        cen_d   = 1'b0;
                        state_d = DONE;
                    end else if (rem_q == 5'd0) begin
                        err_d   = 1'b1;
                        cen_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ABORT: begin
                if (clk_en_q) begin
                    rst_cu_d = 1'b0;
                    state_d  = IDLE;
                end
            end
        endcase

        if (bus.abort && state_q != IDLE && state_q != ABORT) begin
            ld_d     = 1'b0;
            cen_d    = 1'b0;
            rst_cu_d = 1'b1;
            state_d  = ABORT;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            clk_en_q <= 1'b0;
            co_q     <= 1'b0;
            pin_q    <= 4'd0;
            rem_q    <= 5'd0;
            ld_q     <= 1'b0;
            cen_q    <= 1'b0;
            rst_cu_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            clk_en_q <= clk_en_d;
            co_q     <= co_d;
            pin_q    <= pin_d;
            rem_q    <= rem_d;
            ld_q     <= ld_d;
            cen_q    <= cen_d;
            rst_cu_q <= rst_cu_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.clk_en = clk_en_q;
    assign bus.pin    = pin_q;
    assign bus.ld     = ld_q;
    assign bus.cen    = cen_q;
    assign bus.rst_cu = rst_cu_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
endmodule
